// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter
//  Description : Round-robin sharing of one 8-digit seven-segment driver
//                between four requesters, with a minimum dwell per owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [127:0] reqValue,
    input  logic [31:0]  reqEnable,
    input  logic [31:0]  reqPoint,
    output logic [3:0]   grant,
    output logic [31:0]  dispValue,
    output logic [7:0]   dispEnable,
    output logic [7:0]   dispPoint
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [31:0] c_CNT_MAX = 32'(DWELL - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_owner;
    logic [1:0]  w_nextOwner;
    logic [1:0]  r_last;
    logic [1:0]  w_nextLast;
    logic [31:0] r_cnt;
    logic [31:0] w_nextCnt;

    logic [1:0]  w_base;
    logic [1:0]  w_winner;
    logic        w_found;
    logic [3:0]  w_ownerMask;
    logic        w_otherReq;
    logic        w_expired;
    logic        w_load;
    logic        w_blank;
    logic [1:0]  w_sel;

    // While owning, the search starts after the current owner, which is
    // exactly where last will point once ownership moves on.
    assign w_base      = (r_state == OWN) ? r_owner : r_last;
    assign w_ownerMask = 4'b0001 << r_owner;
    assign w_otherReq  = |(req & ~w_ownerMask);
    assign w_expired   = (r_cnt == c_CNT_MAX);

    // Descending offset so the nearest requester after the base wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = w_base;
        for (int k = 4; k >= 1; k--) begin
            if (req[w_base + 2'(k)]) begin
                w_found  = 1'b1;
                w_winner = w_base + 2'(k);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_nextLast  = r_last;
        w_nextCnt   = r_cnt;
        w_load      = 1'b0;
        w_blank     = 1'b0;
        w_sel       = r_owner;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nextState = OWN;
                    w_nextOwner = w_winner;
                    w_nextCnt   = '0;
                    w_load      = 1'b1;
                    w_sel       = w_winner;
                end else begin
                    w_blank = 1'b1;
                end
            end
            OWN: begin
                if (!req[r_owner]) begin
                    w_nextLast = r_owner;
                    if (w_found) begin
                        w_nextOwner = w_winner;
                        w_nextCnt   = '0;
                        w_load      = 1'b1;
                        w_sel       = w_winner;
                    end else begin
                        w_nextState = IDLE;
                        w_blank     = 1'b1;
                    end
                end else if (w_expired && w_otherReq) begin
                    w_nextLast  = r_owner;
                    w_nextOwner = w_winner;
                    w_nextCnt   = '0;
                    w_load      = 1'b1;
                    w_sel       = w_winner;
                end else begin
                    w_load = 1'b1;
                    if (!w_expired) begin
                        w_nextCnt = r_cnt + 32'd1;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_owner    <= 2'd0;
            r_last     <= 2'd3;
            r_cnt      <= '0;
            grant      <= '0;
            dispValue  <= '0;
            dispEnable <= '0;
            dispPoint  <= '0;
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
            r_last  <= w_nextLast;
            r_cnt   <= w_nextCnt;
            if (w_load) begin
                grant      <= 4'b0001 << w_sel;
                dispValue  <= reqValue[{w_sel, 5'b00000} +: 32];
                dispEnable <= reqEnable[{w_sel, 3'b000} +: 8];
                dispPoint  <= reqPoint[{w_sel, 3'b000} +: 8];
            end else if (w_blank) begin
                grant      <= '0;
                dispEnable <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_arbiter
//  Description : Self-checking bench for display_arbiter with DWELL = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int unsigned c_DWELL = 4;

    localparam logic [31:0] c_V0 = 32'hA0A0A0A0;
    localparam logic [31:0] c_V1 = 32'hB1B1B1B1;
    localparam logic [31:0] c_V2 = 32'h12345678;
    localparam logic [31:0] c_V3 = 32'hD3D3D3D3;
    localparam logic [7:0]  c_E0 = 8'h0F;
    localparam logic [7:0]  c_E1 = 8'hF0;
    localparam logic [7:0]  c_E2 = 8'hFF;
    localparam logic [7:0]  c_E3 = 8'h3C;
    localparam logic [7:0]  c_P0 = 8'h80;
    localparam logic [7:0]  c_P1 = 8'h40;
    localparam logic [7:0]  c_P2 = 8'h01;
    localparam logic [7:0]  c_P3 = 8'h02;

    typedef struct packed {
        logic [3:0]  grant;
        logic [31:0] value;
        logic [7:0]  enable;
        logic [7:0]  point;
    } out_t;

    typedef struct packed {
        logic [3:0] req;
        out_t       exp;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] reqValue;
    logic [31:0]  reqEnable;
    logic [31:0]  reqPoint;
    logic [3:0]   grant;
    logic [31:0]  dispValue;
    logic [7:0]   dispEnable;
    logic [7:0]   dispPoint;

    out_t sbq[$];
    int   nChecks = 0;
    int   nFails  = 0;
    vec_t tbl[23];

    always #5 clock = ~clock;

    display_arbiter #(.DWELL(c_DWELL)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .reqValue   (reqValue),
        .reqEnable  (reqEnable),
        .reqPoint   (reqPoint),
        .grant      (grant),
        .dispValue  (dispValue),
        .dispEnable (dispEnable),
        .dispPoint  (dispPoint)
    );

    function automatic out_t mk(input logic [3:0] g, input logic [31:0] v,
                                input logic [7:0] e, input logic [7:0] p);
        out_t o;
        o.grant  = g;
        o.value  = v;
        o.enable = e;
        o.point  = p;
        return o;
    endfunction

    task automatic setSlices();
        reqValue  = {c_V3, c_V2, c_V1, c_V0};
        reqEnable = {c_E3, c_E2, c_E1, c_E0};
        reqPoint  = {c_P3, c_P2, c_P1, c_P0};
    endtask

    task automatic popCheck(input string name);
        out_t act;
        out_t e;
        act = {grant, dispValue, dispEnable, dispPoint};
        nChecks++;
        if (sbq.size() == 0) begin
            nFails++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sbq.pop_front();
        if (act !== e) begin
            nFails++;
            $display("FAIL %s: got grant=%b value=%h enable=%h point=%h, expected grant=%b value=%h enable=%h point=%h",
                     name, act.grant, act.value, act.enable, act.point,
                     e.grant, e.value, e.enable, e.point);
        end
    endtask

    task automatic step(input logic [3:0] r, input out_t e, input string name);
        req = r;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        popCheck(name);
    endtask

    initial begin
        tbl[0]  = '{4'b0100, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[1]  = '{4'b0100, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[2]  = '{4'b0100, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[3]  = '{4'b0100, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[4]  = '{4'b0100, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[5]  = '{4'b0000, mk(4'b0000, c_V2, 8'h00, c_P2)};
        tbl[6]  = '{4'b0000, mk(4'b0000, c_V2, 8'h00, c_P2)};
        tbl[7]  = '{4'b1001, mk(4'b1000, c_V3, c_E3, c_P3)};
        tbl[8]  = '{4'b1001, mk(4'b1000, c_V3, c_E3, c_P3)};
        tbl[9]  = '{4'b1001, mk(4'b1000, c_V3, c_E3, c_P3)};
        tbl[10] = '{4'b1001, mk(4'b1000, c_V3, c_E3, c_P3)};
        tbl[11] = '{4'b1001, mk(4'b0001, c_V0, c_E0, c_P0)};
        tbl[12] = '{4'b0101, mk(4'b0001, c_V0, c_E0, c_P0)};
        tbl[13] = '{4'b0100, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[14] = '{4'b0100, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[15] = '{4'b0110, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[16] = '{4'b0110, mk(4'b0100, c_V2, c_E2, c_P2)};
        tbl[17] = '{4'b0010, mk(4'b0010, c_V1, c_E1, c_P1)};
        tbl[18] = '{4'b0010, mk(4'b0010, c_V1, c_E1, c_P1)};
        tbl[19] = '{4'b0010, mk(4'b0010, c_V1, c_E1, c_P1)};
        tbl[20] = '{4'b0010, mk(4'b0010, c_V1, c_E1, c_P1)};
        tbl[21] = '{4'b1010, mk(4'b1000, c_V3, c_E3, c_P3)};
        tbl[22] = '{4'b0000, mk(4'b0000, c_V3, 8'h00, c_P3)};

        reset = 1'b0;
        req   = 4'b1111;
        setSlices();
        repeat (3) @(posedge clock);
        #1;
        sbq.push_back(mk(4'b0000, 32'h0, 8'h00, 8'h00));
        popCheck("reset_hold");
        reset = 1'b1;

        // Full contention: each owner holds exactly DWELL cycles in turn.
        for (int k = 0; k < 17; k++) begin
            int own;
            own = (k / 4) % 4;
            step(4'b1111, mk(4'(1 << own), reqValue[32*own +: 32],
                             reqEnable[8*own +: 8], reqPoint[8*own +: 8]),
                 $sformatf("rotate_%0d", k));
        end
        step(4'b0000, mk(4'b0000, c_V0, 8'h00, c_P0), "drop_all");
        step(4'b0000, mk(4'b0000, c_V0, 8'h00, c_P0), "idle_hold");

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].req, tbl[i].exp, $sformatf("vec_%0d", i));
        end

        // Live update of the owner's slice; another slice also changes.
        reqValue[63:32] = 32'hAAAA0000;
        step(4'b0010, mk(4'b0010, 32'hAAAA0000, c_E1, c_P1), "live_grant");
        reqValue[63:32] = 32'h0000BBBB;
        reqValue[31:0]  = 32'h55555555;
        reqEnable[15:8] = 8'hC3;
        step(4'b0010, mk(4'b0010, 32'h0000BBBB, 8'hC3, c_P1), "live_update");
        step(4'b0000, mk(4'b0000, 32'h0000BBBB, 8'h00, c_P1), "live_release");

        setSlices();
        step(4'b1000, mk(4'b1000, c_V3, c_E3, c_P3), "own3_cnt0");
        step(4'b1000, mk(4'b1000, c_V3, c_E3, c_P3), "own3_cnt1");
        step(4'b1000, mk(4'b1000, c_V3, c_E3, c_P3), "own3_cnt2");
        reset = 1'b0;
        #1;
        sbq.push_back(mk(4'b0000, 32'h0, 8'h00, 8'h00));
        popCheck("async_reset");
        #1;
        reset = 1'b1;
        step(4'b0110, mk(4'b0010, c_V1, c_E1, c_P1), "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 8-digit seven-segment display driver between four requesters (e.g. CPU register view, accelerator status, debug counters, error codes). Round-robin arbitration with a minimum dwell time per owner, so contended sources alternate at a readable rate. The granted requester's value, enable and point words are registered and fed to the display driver. When no one requests, the display is blanked.

## Interface
Parameters:
- `DWELL`, default 50_000_000: minimum ownership time in clock cycles under contention; legal range 1 to 2^32-1.

Ports:
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset; logic is in reset while `reset` = 0.
- `req` in 4: request per requester; bit i belongs to requester i.
- `reqValue` in 128: hex digits; requester i owns bits [32i+31:32i].
- `reqEnable` in 32: digit enables; requester i owns bits [8i+7:8i].
- `reqPoint` in 32: decimal points; requester i owns bits [8i+7:8i].
- `grant` out 4: one-hot registered grant, all zero when idle.
- `dispValue` out 32: registered value to the display driver.
- `dispEnable` out 8: registered digit enables to the display driver.
- `dispPoint` out 8: registered points to the display driver.

## Operation
- State: `IDLE` or `OWN`. Also a 2-bit `owner`, a 2-bit `last` (round-robin pointer) and a 32-bit dwell counter `cnt`.
- Reset values: state `IDLE`, `grant`=0, `dispValue`=0, `dispEnable`=0, `dispPoint`=0, `cnt`=0, `last`=3. Requester 0 therefore wins first.
- Winner selection: search `last`+1, `last`+2, `last`+3, `last` (mod 4). The first index with `req` high wins.
- In `IDLE`:
  - If any `req` bit is high, go to `OWN` with the winner. Set `grant` one-hot, set `cnt`=0 and load the winner's value/enable/point slices into the `disp*` registers.
  - Otherwise stay in `IDLE`. Force `dispEnable`=0; `dispValue` and `dispPoint` hold.
- In `OWN`, the `expired` condition is `cnt` == `DWELL`-1. `cnt` increments each cycle and saturates at `DWELL`-1.
- Each edge in `OWN`, in priority order:
  1. Owner's `req` low: release. Set `last`=`owner`, then re-arbitrate in the same edge. If another request is pending, grant it directly (no idle cycle). Otherwise go to `IDLE` with `grant`=0 and `dispEnable`=0.
  2. `expired` and some other `req` high: set `last`=`owner` and hand over to the next winner. Reset `cnt`=0 and load the new owner's slices.
  3. Otherwise keep ownership. Reload the owner's slices every cycle (live update).
- At most one `grant` bit is ever high. `grant` and the `disp*` outputs always change on the same edge.
- A lone owner keeps the display indefinitely; expiry alone never releases it.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Grant latency: `req` high sampled at edge N in `IDLE` gives `grant` and `disp*` valid after edge N.
- Data latency: a change of the owner's slices sampled at edge N appears on `disp*` after edge N (1 cycle).
- Release latency: owner `req` low sampled at edge N gives the new `grant` (or all zero) after edge N.
- Dwell under contention: an owner granted at edge E keeps `grant` through edges E+1 … E+`DWELL`-1. Handover occurs at edge E+`DWELL` at the earliest.
- `DWELL`=1: contended requesters rotate every cycle.
- Simultaneous events:
  - Owner drop and expiry on the same edge: the drop rule applies.
  - A request arriving on the handover edge takes part in that edge's search.
- Reset asserted mid-ownership: all state and outputs clear immediately (asynchronously) to the reset values. The first edge after release behaves as `IDLE` with `last`=3.

## Test plan
- Reset: hold `reset`=0 with all `req`=1 → `grant`=0, `disp*`=0. After release, the first edge gives `grant`=0001.
- Single requester, `DWELL`=4: `req`=0100, slice 2 = 0x12345678/FF/01 → after the next edge `grant`=0100 and `disp*`=0x12345678/FF/01. Drop `req` → next edge `grant`=0000, `dispEnable`=00, `dispValue` still 0x12345678.
- Full contention, `DWELL`=4: `req`=1111 from reset → `grant` sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
- Early release: `req`=0101 with owner 0, drop `req[0]` at cnt=1 → next edge `grant`=0100, `cnt`=0, no blank cycle.
- Live update: owner 1 changes value 0xAAAA0000 → 0x0000BBBB at edge N → `dispValue`=0x0000BBBB after edge N. Other requesters are unaffected.
- Mid-operation reset: owner 3 at cnt=2, pulse `reset` low between edges → outputs 0 immediately. Then with `req`=0110, the first edge gives `grant`=0010.
